// File: rtl/framebuffer_blend_rmw_if.sv
// Bus bundle of the framebuffer read-modify-write sequencer: fragment input,
// framebuffer read/write ports and the external blender connection.
interface framebuffer_blend_rmw_if #(
   parameter int SUB_PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH      = 16
);
   localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;

   // Handshakes: a transfer happens on a rising clock edge where valid and ready
   // are both 1; a master holds valid and payload stable until that edge.
   // rd_data_valid is a plain strobe with no backpressure.
   logic                   s_frag_valid;
   logic                   s_frag_ready;
   logic [ADDR_WIDTH-1:0]  s_frag_addr;
   logic [PIXEL_WIDTH-1:0] s_frag_color;
   logic                   s_frag_blend_en;

   logic                   m_rd_valid;
   logic                   m_rd_ready;
   logic [ADDR_WIDTH-1:0]  m_rd_addr;
   logic                   rd_data_valid;
   logic [PIXEL_WIDTH-1:0] rd_data;

   logic [PIXEL_WIDTH-1:0] blend_src_color;
   logic [PIXEL_WIDTH-1:0] blend_dest_color;
   logic [PIXEL_WIDTH-1:0] blend_color;

   logic                   m_wr_valid;
   logic                   m_wr_ready;
   logic [ADDR_WIDTH-1:0]  m_wr_addr;
   logic [PIXEL_WIDTH-1:0] m_wr_data;

   modport master (
      input  s_frag_valid, s_frag_addr, s_frag_color, s_frag_blend_en,
      input  m_rd_ready, rd_data_valid, rd_data, blend_color, m_wr_ready,
      output s_frag_ready, m_rd_valid, m_rd_addr,
      output blend_src_color, blend_dest_color,
      output m_wr_valid, m_wr_addr, m_wr_data
   );

   modport slave (
      output s_frag_valid, s_frag_addr, s_frag_color, s_frag_blend_en,
      output m_rd_ready, rd_data_valid, rd_data, blend_color, m_wr_ready,
      input  s_frag_ready, m_rd_valid, m_rd_addr,
      input  blend_src_color, blend_dest_color,
      input  m_wr_valid, m_wr_addr, m_wr_data
   );
endinterface

// File: rtl/framebuffer_blend_rmw.sv
// Read-modify-write sequencer between the fragment pipeline and the color buffer:
// fetch destination pixel, wait out the external blender, write the result back.
module framebuffer_blend_rmw #(
   parameter int SUB_PIXEL_WIDTH = 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int BLEND_LATENCY   = 1
) (
   input  logic                  aclk,
   input  logic                  resetn,
   framebuffer_blend_rmw_if.master bus,
   output logic                  busy,
   output logic                  rd_stray,
   output logic [2:0]            dbg_state
);
   localparam int PIXEL_WIDTH = 4 * SUB_PIXEL_WIDTH;
   localparam int CW = (BLEND_LATENCY < 1) ? 1 : $clog2(BLEND_LATENCY + 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      BLEND   = 3'd3,
      WR      = 3'd4
   } state_t;

   state_t                 state, state_d;
   logic [ADDR_WIDTH-1:0]  addr_q;
   logic [PIXEL_WIDTH-1:0] src_q;
   logic [PIXEL_WIDTH-1:0] dst_q;
   logic [PIXEL_WIDTH-1:0] wr_data_q;
   logic [CW-1:0]          cnt_q;
   logic                   frag_ready;
   logic                   rd_valid;
   logic                   wr_valid;
   logic                   frag_hs;

   always_comb begin
      state_d    = state;
      frag_ready = 1'b0;
      rd_valid   = 1'b0;
      wr_valid   = 1'b0;
      case (state)
         IDLE: begin
            frag_ready = resetn;
            if (bus.s_frag_valid && resetn)
               state_d = bus.s_frag_blend_en ? RD_REQ : WR;
         end
         RD_REQ: begin
            rd_valid = 1'b1;
            if (bus.m_rd_ready) state_d = RD_WAIT;
         end
         RD_WAIT: begin
            if (bus.rd_data_valid) state_d = BLEND;
         end
         BLEND: begin
            if (cnt_q == '0) state_d = WR;
         end
         WR: begin
            wr_valid = 1'b1;
            if (bus.m_wr_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign frag_hs = bus.s_frag_valid && frag_ready;

   always_ff @(posedge aclk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         addr_q    <= '0;
         src_q     <= '0;
         dst_q     <= '0;
         wr_data_q <= '0;
         cnt_q     <= '0;
         rd_stray  <= 1'b0;
      end else begin
         state <= state_d;
         if (frag_hs) begin
            addr_q <= bus.s_frag_addr;
            src_q  <= bus.s_frag_color;
            if (!bus.s_frag_blend_en) wr_data_q <= bus.s_frag_color;
         end
         if (state == RD_WAIT && bus.rd_data_valid) begin
            dst_q <= bus.rd_data;
            cnt_q <= CW'(BLEND_LATENCY);
         end
         // Blender output is only trusted once its whole pipeline has seen the captured inputs.
         if (state == BLEND) begin
            if (cnt_q == '0) wr_data_q <= bus.blend_color;
            else             cnt_q     <= cnt_q - 1'b1;
         end
         if (bus.rd_data_valid && state != RD_WAIT) rd_stray <= 1'b1;
      end
   end

   assign bus.s_frag_ready     = frag_ready;
   assign bus.m_rd_valid       = rd_valid;
   assign bus.m_rd_addr        = addr_q;
   assign bus.m_wr_valid       = wr_valid;
   assign bus.m_wr_addr        = addr_q;
   assign bus.m_wr_data        = wr_data_q;
   assign bus.blend_src_color  = src_q;
   assign bus.blend_dest_color = dst_q;
   assign busy                 = (state != IDLE);
   assign dbg_state            = state;
endmodule

// File: tb/tb_framebuffer_blend_rmw.sv
// Bench for framebuffer_blend_rmw: directed timing scenarios plus a randomized
// fragment stream checked against an in-order write model.
`timescale 1ns/1ps
module tb_framebuffer_blend_rmw;
   localparam int SPW = 8;
   localparam int AW  = 16;
   localparam int PW  = 32;

   // clock / reset
   logic aclk = 1'b0;
   logic resetn;
   always #5 aclk = ~aclk;

   framebuffer_blend_rmw_if #(.SUB_PIXEL_WIDTH(SPW), .ADDR_WIDTH(AW)) bus_a ();
   framebuffer_blend_rmw_if #(.SUB_PIXEL_WIDTH(SPW), .ADDR_WIDTH(AW)) bus_b ();

   logic       busy_a, stray_a, busy_b, stray_b;
   logic [2:0] st_a, st_b;

   framebuffer_blend_rmw #(.SUB_PIXEL_WIDTH(SPW), .ADDR_WIDTH(AW), .BLEND_LATENCY(1)) dut_a (
      .aclk(aclk), .resetn(resetn), .bus(bus_a),
      .busy(busy_a), .rd_stray(stray_a), .dbg_state(st_a));

   framebuffer_blend_rmw #(.SUB_PIXEL_WIDTH(SPW), .ADDR_WIDTH(AW), .BLEND_LATENCY(3)) dut_b (
      .aclk(aclk), .resetn(resetn), .bus(bus_b),
      .busy(busy_b), .rd_stray(stray_b), .dbg_state(st_b));

   // stub blenders: bitwise OR, 1 stage for dut_a, 3 stages for dut_b
   always_ff @(posedge aclk) bus_a.blend_color <= bus_a.blend_src_color | bus_a.blend_dest_color;
   logic [PW-1:0] b_pipe [0:2];
   always_ff @(posedge aclk) begin
      b_pipe[0] <= bus_b.blend_src_color | bus_b.blend_dest_color;
      b_pipe[1] <= b_pipe[0];
      b_pipe[2] <= b_pipe[1];
   end
   assign bus_b.blend_color = b_pipe[2];

   int n_checks = 0;
   int n_pass   = 0;

   logic          rd_ready_fix = 1'b1;
   logic          wr_ready_fix = 1'b1;
   logic          rand_stall   = 1'b0;
   logic          resp_block   = 1'b0;
   int            stray_req_cnt = 0;
   int            stray_done    = 0;
   int            rd_req_cnt    = 0;
   int            rd_served     = 0;
   int            wr_cnt        = 0;
   logic [AW-1:0] rd_req_addr;
   logic [PW-1:0] fb_mem [0:1023];
   logic [AW+PW-1:0] got_q [$];
   logic [AW+PW-1:0] exp_q [$];

   // ready driver for dut_a
   initial begin
      bus_a.m_rd_ready = 1'b1;
      bus_a.m_wr_ready = 1'b1;
      forever begin
         @(posedge aclk); #2;
         if (rand_stall) begin
            bus_a.m_rd_ready = ($urandom_range(0, 2) != 0);
            bus_a.m_wr_ready = ($urandom_range(0, 2) != 0);
         end else begin
            bus_a.m_rd_ready = rd_ready_fix;
            bus_a.m_wr_ready = wr_ready_fix;
         end
      end
   end

   // read responder for dut_a: one cycle after the request handshake
   initial begin
      bus_a.rd_data_valid = 1'b0;
      bus_a.rd_data       = '0;
      forever begin
         @(posedge aclk); #2;
         bus_a.rd_data_valid = 1'b0;
         if (stray_req_cnt != stray_done) begin
            stray_done          = stray_req_cnt;
            bus_a.rd_data_valid = 1'b1;
            bus_a.rd_data       = 32'hdeadbeef;
         end else if (rd_req_cnt != rd_served && !resp_block) begin
            rd_served           = rd_served + 1;
            bus_a.rd_data_valid = 1'b1;
            bus_a.rd_data       = fb_mem[rd_req_addr[9:0]];
         end
      end
   end

   // bus monitor for dut_a, sampled mid-cycle
   initial begin
      forever begin
         @(negedge aclk);
         if (resetn && bus_a.m_rd_valid && bus_a.m_rd_ready) begin
            rd_req_cnt  = rd_req_cnt + 1;
            rd_req_addr = bus_a.m_rd_addr;
         end
         if (resetn && bus_a.m_wr_valid && bus_a.m_wr_ready) begin
            wr_cnt = wr_cnt + 1;
            got_q.push_back({bus_a.m_wr_addr, bus_a.m_wr_data});
         end
      end
   end

   task automatic tick();
      @(posedge aclk); #1;
   endtask

   task automatic send_frag(input logic [AW-1:0] a, input logic [PW-1:0] c, input logic be);
      int t;
      t = 0;
      bus_a.s_frag_valid    = 1'b1;
      bus_a.s_frag_addr     = a;
      bus_a.s_frag_color    = c;
      bus_a.s_frag_blend_en = be;
      while (bus_a.s_frag_ready !== 1'b1 && t < 500) begin
         tick();
         t++;
      end
      n_checks++;
      if (t >= 500) $display("FAIL send_timeout: waited %0d cycles, limit 500", t);
      else n_pass++;
      tick();
      bus_a.s_frag_valid = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      n_checks++; if (bus_a.s_frag_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus_a.s_frag_ready); else n_pass++;
      n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_a); else n_pass++;
      n_checks++; if (bus_a.m_rd_valid !== 1'b0 || bus_a.m_wr_valid !== 1'b0)
         $display("FAIL reset_valids: got rd=%b wr=%b want 0 0", bus_a.m_rd_valid, bus_a.m_wr_valid); else n_pass++;
      n_checks++; if (stray_a !== 1'b0) $display("FAIL reset_stray: got %b want 0", stray_a); else n_pass++;
      n_checks++; if ({bus_a.m_rd_addr, bus_a.m_wr_addr, bus_a.m_wr_data} !== '0)
         $display("FAIL reset_addr_data: got %h %h %h want 0", bus_a.m_rd_addr, bus_a.m_wr_addr, bus_a.m_wr_data); else n_pass++;
      n_checks++; if ({bus_a.blend_src_color, bus_a.blend_dest_color} !== '0)
         $display("FAIL reset_blend_out: got %h %h want 0", bus_a.blend_src_color, bus_a.blend_dest_color); else n_pass++;
      n_checks++; if (busy_b !== 1'b0 || bus_b.s_frag_ready !== 1'b0)
         $display("FAIL reset_b: got busy=%b ready=%b want 0 0", busy_b, bus_b.s_frag_ready); else n_pass++;
      resetn = 1'b1;
      #1;
      n_checks++; if (bus_a.s_frag_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", bus_a.s_frag_ready); else n_pass++;
      tick();
   endtask

   task automatic test_bypass();
      int base_rd, base_q;
      base_rd = rd_req_cnt;
      base_q  = got_q.size();
      bus_a.s_frag_valid = 1'b1;
      bus_a.s_frag_addr = 16'h0010;
      bus_a.s_frag_color = 32'h11223344;
      bus_a.s_frag_blend_en = 1'b0;
      n_checks++; if (bus_a.s_frag_ready !== 1'b1) $display("FAIL bypass_c0_ready: got %b want 1", bus_a.s_frag_ready); else n_pass++;
      tick();
      bus_a.s_frag_valid = 1'b0;
      n_checks++; if ({bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data} !== {1'b1, 16'h0010, 32'h11223344})
         $display("FAIL bypass_c1_write: got v=%b a=%h d=%h want 1 0010 11223344", bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data); else n_pass++;
      n_checks++; if (bus_a.s_frag_ready !== 1'b0 || bus_a.m_rd_valid !== 1'b0)
         $display("FAIL bypass_c1_ready_rd: got ready=%b rd=%b want 0 0", bus_a.s_frag_ready, bus_a.m_rd_valid); else n_pass++;
      tick();
      n_checks++; if (bus_a.s_frag_ready !== 1'b1 || bus_a.m_wr_valid !== 1'b0)
         $display("FAIL bypass_c2: got ready=%b wr=%b want 1 0", bus_a.s_frag_ready, bus_a.m_wr_valid); else n_pass++;
      n_checks++; if (rd_req_cnt != base_rd || got_q.size() != base_q + 1)
         $display("FAIL bypass_counts: got reads=%0d writes=%0d want 0 1", rd_req_cnt - base_rd, got_q.size() - base_q); else n_pass++;
   endtask

   task automatic test_blend();
      logic [PW-1:0] expv;
      fb_mem[10'h200] = 32'h0000ffff;
      expv = 32'hff000080 | 32'h0000ffff;
      bus_a.s_frag_valid = 1'b1;
      bus_a.s_frag_addr = 16'h0200;
      bus_a.s_frag_color = 32'hff000080;
      bus_a.s_frag_blend_en = 1'b1;
      tick();  // c1
      bus_a.s_frag_valid = 1'b0;
      n_checks++; if ({bus_a.m_rd_valid, bus_a.m_rd_addr} !== {1'b1, 16'h0200})
         $display("FAIL blend_c1_read: got v=%b a=%h want 1 0200", bus_a.m_rd_valid, bus_a.m_rd_addr); else n_pass++;
      tick();  // c2
      n_checks++; if (busy_a !== 1'b1 || bus_a.m_rd_valid !== 1'b0)
         $display("FAIL blend_c2: got busy=%b rd=%b want 1 0", busy_a, bus_a.m_rd_valid); else n_pass++;
      tick();  // c3
      n_checks++; if ({bus_a.blend_src_color, bus_a.blend_dest_color} !== {32'hff000080, 32'h0000ffff})
         $display("FAIL blend_c3_inputs: got %h %h want ff000080 0000ffff", bus_a.blend_src_color, bus_a.blend_dest_color); else n_pass++;
      tick();  // c4
      n_checks++; if (bus_a.m_wr_valid !== 1'b0) $display("FAIL blend_c4_early_write: got %b want 0", bus_a.m_wr_valid); else n_pass++;
      tick();  // c5
      n_checks++; if ({bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data} !== {1'b1, 16'h0200, expv})
         $display("FAIL blend_c5_write: got v=%b a=%h d=%h want 1 0200 %h", bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data, expv); else n_pass++;
      tick();  // c6
      n_checks++; if (bus_a.s_frag_ready !== 1'b1) $display("FAIL blend_c6_ready: got %b want 1", bus_a.s_frag_ready); else n_pass++;
   endtask

   task automatic test_backpressure();
      int base_rd, base_wr;
      logic [PW-1:0] src, dst, expv;
      src = $urandom;
      dst = $urandom;
      expv = src | dst;
      fb_mem[10'h033] = dst;
      base_rd = rd_req_cnt;
      base_wr = wr_cnt;
      rd_ready_fix = 1'b0;
      wr_ready_fix = 1'b0;
      bus_a.s_frag_valid = 1'b1;
      bus_a.s_frag_addr = 16'h0033;
      bus_a.s_frag_color = src;
      bus_a.s_frag_blend_en = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         bus_a.s_frag_valid = 1'b0;
         rd_ready_fix = (c >= 4);
         wr_ready_fix = (c >= 12);
         if (c <= 4) begin
            n_checks++; if ({bus_a.m_rd_valid, bus_a.m_rd_addr} !== {1'b1, 16'h0033})
               $display("FAIL bp_read_hold c%0d: got v=%b a=%h want 1 0033", c, bus_a.m_rd_valid, bus_a.m_rd_addr); else n_pass++;
         end
         if (c >= 5 && c <= 7) begin
            n_checks++; if (bus_a.m_rd_valid !== 1'b0 || bus_a.m_wr_valid !== 1'b0)
               $display("FAIL bp_mid c%0d: got rd=%b wr=%b want 0 0", c, bus_a.m_rd_valid, bus_a.m_wr_valid); else n_pass++;
         end
         if (c >= 8 && c <= 12) begin
            n_checks++; if ({bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data} !== {1'b1, 16'h0033, expv})
               $display("FAIL bp_write_hold c%0d: got v=%b a=%h d=%h want 1 0033 %h", c, bus_a.m_wr_valid, bus_a.m_wr_addr, bus_a.m_wr_data, expv); else n_pass++;
         end
      end
      n_checks++; if (bus_a.s_frag_ready !== 1'b1) $display("FAIL bp_c13_ready: got %b want 1", bus_a.s_frag_ready); else n_pass++;
      n_checks++; if (rd_req_cnt - base_rd != 1 || wr_cnt - base_wr != 1)
         $display("FAIL bp_counts: got reads=%0d writes=%0d want 1 1", rd_req_cnt - base_rd, wr_cnt - base_wr); else n_pass++;
      rd_ready_fix = 1'b1;
      wr_ready_fix = 1'b1;
   endtask

   task automatic test_latency3();
      logic [PW-1:0] src, dst, expv;
      logic [AW-1:0] a;
      bus_b.m_rd_ready = 1'b1;
      bus_b.m_wr_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         src = $urandom;
         dst = $urandom;
         a = AW'(16'h0040 + k);
         expv = src | dst;
         bus_b.s_frag_valid = 1'b1;
         bus_b.s_frag_addr = a;
         bus_b.s_frag_color = src;
         bus_b.s_frag_blend_en = 1'b1;
         n_checks++; if (bus_b.s_frag_ready !== 1'b1) $display("FAIL lat3_c0_ready[%0d]: got %b want 1", k, bus_b.s_frag_ready); else n_pass++;
         tick();  // c1
         bus_b.s_frag_valid = 1'b0;
         n_checks++; if ({bus_b.m_rd_valid, bus_b.m_rd_addr} !== {1'b1, a})
            $display("FAIL lat3_read[%0d]: got v=%b a=%h want 1 %h", k, bus_b.m_rd_valid, bus_b.m_rd_addr, a); else n_pass++;
         tick();  // c2
         bus_b.rd_data_valid = 1'b1;
         bus_b.rd_data = dst;
         tick();  // c3
         bus_b.rd_data_valid = 1'b0;
         for (int c = 3; c <= 6; c++) begin
            n_checks++; if (bus_b.m_wr_valid !== 1'b0 || busy_b !== 1'b1 || bus_b.blend_src_color !== src || bus_b.blend_dest_color !== dst)
               $display("FAIL lat3_blend[%0d] c%0d: got wr=%b busy=%b src=%h dst=%h want 0 1 %h %h",
                        k, c, bus_b.m_wr_valid, busy_b, bus_b.blend_src_color, bus_b.blend_dest_color, src, dst); else n_pass++;
            tick();
         end
         n_checks++; if ({bus_b.m_wr_valid, bus_b.m_wr_addr, bus_b.m_wr_data} !== {1'b1, a, expv})
            $display("FAIL lat3_write[%0d]: got v=%b a=%h d=%h want 1 %h %h", k, bus_b.m_wr_valid, bus_b.m_wr_addr, bus_b.m_wr_data, a, expv); else n_pass++;
         tick();
      end
      n_checks++; if (stray_b !== 1'b0) $display("FAIL lat3_stray: got %b want 0", stray_b); else n_pass++;
   endtask

   task automatic test_stray_reset();
      int base_wr;
      n_checks++; if (stray_a !== 1'b0) $display("FAIL stray_pre: got %b want 0", stray_a); else n_pass++;
      stray_req_cnt = stray_req_cnt + 1;
      tick();
      tick();
      n_checks++; if (stray_a !== 1'b1) $display("FAIL stray_idle_set: got %b want 1", stray_a); else n_pass++;
      repeat (5) tick();
      n_checks++; if (stray_a !== 1'b1) $display("FAIL stray_idle_hold: got %b want 1", stray_a); else n_pass++;

      resp_block = 1'b1;
      base_wr = wr_cnt;
      bus_a.s_frag_valid = 1'b1;
      bus_a.s_frag_addr = 16'h0077;
      bus_a.s_frag_color = $urandom;
      bus_a.s_frag_blend_en = 1'b1;
      tick();
      bus_a.s_frag_valid = 1'b0;
      tick();
      tick();
      n_checks++; if (busy_a !== 1'b1 || bus_a.m_rd_valid !== 1'b0)
         $display("FAIL rdwait_pre_reset: got busy=%b rd=%b want 1 0", busy_a, bus_a.m_rd_valid); else n_pass++;
      resetn = 1'b0;
      #1;
      n_checks++; if (busy_a !== 1'b0 || bus_a.m_wr_valid !== 1'b0 || stray_a !== 1'b0 || bus_a.s_frag_ready !== 1'b0)
         $display("FAIL midreset: got busy=%b wr=%b stray=%b ready=%b want 0 0 0 0", busy_a, bus_a.m_wr_valid, stray_a, bus_a.s_frag_ready); else n_pass++;
      tick();
      tick();
      resetn = 1'b1;
      repeat (4) tick();
      n_checks++; if (wr_cnt != base_wr || busy_a !== 1'b0 || stray_a !== 1'b0)
         $display("FAIL post_reset: got writes=%0d busy=%b stray=%b want 0 0 0", wr_cnt - base_wr, busy_a, stray_a); else n_pass++;
      resp_block = 1'b0;
      tick();
      tick();
      n_checks++; if (stray_a !== 1'b1) $display("FAIL late_response_stray: got %b want 1", stray_a); else n_pass++;

      send_frag(16'h0123, 32'hcafef00d, 1'b0);
      tick();
      n_checks++; if (wr_cnt - base_wr != 1 || got_q[$] !== {16'h0123, 32'hcafef00d})
         $display("FAIL post_reset_frag: got writes=%0d last=%h want 1 0123cafef00d", wr_cnt - base_wr, got_q[$]); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int base_q, t;
      logic [AW-1:0] a;
      logic [PW-1:0] c;
      logic be;
      for (int i = 0; i < 8; i++) fb_mem[i] = $urandom;
      base_q = got_q.size();
      rand_stall = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a  = AW'($urandom_range(0, 7));
         c  = $urandom;
         be = (i < 2) ? (i == 0) : 1'($urandom_range(0, 1));
         // destination buffer is a fixed image; blended result = src | dest
         exp_q.push_back({a, be ? (c | fb_mem[a[9:0]]) : c});
         send_frag(a, c, be);
      end
      t = 0;
      while (got_q.size() < base_q + 8 && t < 2000) begin
         tick();
         t++;
      end
      n_checks++; if (got_q.size() != base_q + 8)
         $display("FAIL b2b_write_count: got %0d want 8 after %0d cycles", got_q.size() - base_q, t); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (base_q + i >= got_q.size()) $display("FAIL b2b_write[%0d]: got none want %h", i, exp_q[i]);
         else if (got_q[base_q + i] !== exp_q[i]) $display("FAIL b2b_write[%0d]: got %h want %h", i, got_q[base_q + i], exp_q[i]);
         else n_pass++;
      end
      rand_stall = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      for (int i = 0; i < 1024; i++) fb_mem[i] = '0;
      bus_a.s_frag_valid = 1'b0;
      bus_a.s_frag_addr = '0;
      bus_a.s_frag_color = '0;
      bus_a.s_frag_blend_en = 1'b0;
      bus_b.s_frag_valid = 1'b0;
      bus_b.s_frag_addr = '0;
      bus_b.s_frag_color = '0;
      bus_b.s_frag_blend_en = 1'b0;
      bus_b.m_rd_ready = 1'b1;
      bus_b.m_wr_ready = 1'b1;
      bus_b.rd_data_valid = 1'b0;
      bus_b.rd_data = '0;

      test_reset();
      test_bypass();
      test_blend();
      test_backpressure();
      test_latency3();
      test_stray_reset();
      test_back_to_back();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/framebuffer_blend_rmw.md
# framebuffer_blend_rmw

- Read-modify-write sequencer between the fragment pipeline and the color buffer.
- Per accepted fragment:
  - Fetches the destination pixel from the framebuffer read port.
  - Presents source and destination colors to the external color blender and waits the blender's fixed pipeline latency.
  - Writes the blended result back to the same address.
- Fragments with blending disabled bypass the read and blend steps and are written directly.

## Interface

Parameters:
- SUB_PIXEL_WIDTH, 8, bits per color channel
- PIXEL_WIDTH, 4*SUB_PIXEL_WIDTH, packed RGBA width (derived, not overridable)
- ADDR_WIDTH, 16, framebuffer pixel address width
- BLEND_LATENCY, 1, register stages of the external blender (minimum 1)

Ports:
- aclk  in  1  clock; single clock domain
- resetn  in  1  reset; asynchronous, active-low
- s_frag_valid  in  1  fragment offered
- s_frag_ready  out  1  fragment accepted when valid&ready
- s_frag_addr  in  ADDR_WIDTH  pixel address
- s_frag_color  in  PIXEL_WIDTH  source RGBA
- s_frag_blend_en  in  1  1 = read/blend/write, 0 = direct write
- m_rd_valid  out  1  read request
- m_rd_ready  in  1  read request accepted
- m_rd_addr  out  ADDR_WIDTH  read address
- rd_data_valid  in  1  read response strobe; no backpressure
- rd_data  in  PIXEL_WIDTH  destination RGBA
- blend_src_color  out  PIXEL_WIDTH  to blender source input
- blend_dest_color  out  PIXEL_WIDTH  to blender destination input
- blend_color  in  PIXEL_WIDTH  blender result
- m_wr_valid  out  1  write request
- m_wr_ready  in  1  write accepted
- m_wr_addr  out  ADDR_WIDTH  write address
- m_wr_data  out  PIXEL_WIDTH  write data
- busy  out  1  state != IDLE
- rd_stray  out  1  sticky: rd_data_valid seen outside RD_WAIT

## Operation

States: IDLE, RD_REQ, RD_WAIT, BLEND, WR.

- IDLE:
  - s_frag_ready = 1 (0 while resetn low).
  - On handshake, register addr, color and blend_en.
  - Next state is RD_REQ if blend_en = 1, otherwise WR with m_wr_data = source color.
- RD_REQ:
  - m_rd_valid = 1 with m_rd_addr = captured addr.
  - Address is held stable until m_rd_ready; on handshake go to RD_WAIT.
- RD_WAIT:
  - On rd_data_valid, capture rd_data into the destination register.
  - Load counter = BLEND_LATENCY; go to BLEND.
  - Waits indefinitely otherwise.
- BLEND:
  - Lasts exactly BLEND_LATENCY+1 cycles; counter decrements each cycle.
  - In the last cycle (counter = 0), register blend_color into m_wr_data; go to WR.
- WR:
  - m_wr_valid = 1; addr/data held until m_wr_ready; on handshake go to IDLE.
- blend_src_color / blend_dest_color:
  - Driven directly from the captured source/destination registers.
  - Stable from BLEND entry through BLEND exit.
- Only one fragment is in flight, so no same-address hazards exist; write completes before the next accept.
- rd_data_valid outside RD_WAIT: data ignored, rd_stray set to 1 until reset.
- rd_data_valid in the same cycle as the RD_REQ handshake: ignored and flagged as stray. The response must arrive at least one cycle after the request handshake.

## Timing

- Reset values:
  - state IDLE; m_rd_valid = 0, m_wr_valid = 0, busy = 0, rd_stray = 0.
  - All address/color registers, m_rd_addr, m_wr_addr, m_wr_data and both blend_* outputs = 0.
  - s_frag_ready = 0 while resetn low, 1 in the first cycle after release.
- Reset asserted mid-operation: immediately abandons the fragment, returns to IDLE, no write issued. A read response arriving afterwards sets rd_stray.
- Blend path, zero-wait memory, response one cycle after request:
  - c0 accept
  - c1 RD_REQ
  - c2 RD_WAIT capture
  - c3..c(3+BLEND_LATENCY) BLEND
  - then one WR cycle
  - next accept one cycle later
  - Total 5+BLEND_LATENCY cycles per fragment (6 at default).
- Bypass path:
  - c0 accept, c1 WR, c2 next accept; 2 cycles per fragment.
- Stalls on m_rd_ready / m_wr_ready extend RD_REQ / WR cycle-for-cycle; outputs hold.

## Test plan

- Bypass: addr 0x0010, color 0x11223344, blend_en 0, m_wr_ready 1 -> m_wr_valid in c1 with addr 0x0010, data 0x11223344; s_frag_ready back to 1 in c2; m_rd_valid never asserted.
- Blend, default latency: addr 0x0200, color 0xFF000080, rd_data 0x0000FFFF one cycle after the read handshake; stub blender = registered bitwise OR -> write of 0xFF00FFFF to 0x0200 in c5; fragment-to-fragment interval 6 cycles.
- Backpressure: m_rd_ready low 3 cycles, then m_wr_ready low 4 cycles -> m_rd_addr/m_wr_addr/m_wr_data stable throughout; exactly one read and one write; interval 13 cycles.
- BLEND_LATENCY=3 with a 3-stage stub blender -> m_wr_data equals the blender output for the captured inputs, never an intermediate value; BLEND lasts 4 cycles.
- Stray/reset:
  - rd_data_valid pulsed in IDLE -> rd_stray = 1 and holds.
  - resetn pulsed low during RD_WAIT -> busy = 0, no m_wr_valid, rd_stray cleared, new fragment accepted normally.
- Back-to-back stream of 8 fragments, mixed blend_en, random ready stalls -> write sequence matches a reference model in order, addresses and data exact.
